// File: rtl/float_decode_pkg.sv
// Shared constants and state encoding for the float-to-two's-complement decoder.
// Also holds the sign/magnitude to two's-complement helper used in the final stage.
package float_decode_pkg;

    localparam int FLT_W  = 11;
    localparam int EXP_W  = 4;
    localparam int MANT_W = 6;
    localparam int MAG_W  = 15;
    localparam int TC_W   = 16;
    localparam int ACC_W  = MAG_W + MANT_W;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN,
        HOLD
    } state_t;

    // A zero magnitude comes out as 0 for either sign, so -0 never appears.
    function automatic logic [TC_W-1:0] to_twos(input logic sign, input logic [MAG_W-1:0] mag);
        logic [TC_W-1:0] w_ext;
        w_ext = {1'b0, mag};
        return sign ? (TC_W'(0) - w_ext) : w_ext;
    endfunction

endpackage

// File: rtl/float_decode.sv
// Serial float decoder: shifts the mantissa left EXP times, then emits the
// signed 16-bit value through a valid/ready handshake held until consumed.
module float_decode
    import float_decode_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_in0,
    input  logic             scan_in1,
    input  logic             scan_in2,
    input  logic             scan_in3,
    input  logic             scan_in4,
    input  logic             scan_enable,
    input  logic             test_mode,
    output logic             scan_out0,
    output logic             scan_out1,
    output logic             scan_out2,
    output logic             scan_out3,
    output logic             scan_out4,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FLT_W-1:0] SR0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TC_W-1:0]  SR,
    output logic             fmt_err
);

    state_t             r_state;
    state_t             w_next;
    logic [ACC_W-1:0]   r_acc;
    logic [EXP_W-1:0]   r_count;
    logic               r_sign;
    logic               r_fmt_err;

    // Scan hooks are placeholders for test insertion; they carry no function here.
    logic w_unused_scan;
    assign w_unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                             scan_enable, test_mode};

    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)        w_next = SHIFT;
            SHIFT:   if (r_count == '0)   w_next = FIN;
            FIN:                          w_next = HOLD;
            HOLD:    if (out_ready)       w_next = IDLE;
            default:                      w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_sign    <= 1'b0;
            r_fmt_err <= 1'b0;
            SR        <= '0;
            fmt_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign    <= SR0[FLT_W-1];
                        r_acc     <= ACC_W'(SR0[MANT_W-1:0]);
                        r_count   <= SR0[FLT_W-2 -: EXP_W];
                        r_fmt_err <= ~SR0[MANT_W-1];
                    end
                end
                SHIFT: begin
                    if (r_count != '0) begin
                        r_acc   <= {r_acc[ACC_W-2:0], 1'b0};
                        r_count <= r_count - EXP_W'(1);
                    end
                end
                // Dropping the low MANT_W bits applies the >>6 with truncation.
                FIN: begin
                    SR      <= to_twos(r_sign, r_acc[ACC_W-1:MANT_W]);
                    fmt_err <= r_fmt_err;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_decode.sv
// Directed and randomized bench for float_decode against an arithmetic model
// of the float format, including latency, handshake and reset-abort behaviour.
module tb_float_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scan_in0 = 1'b0, scan_in1 = 1'b0, scan_in2 = 1'b0, scan_in3 = 1'b0, scan_in4 = 1'b0;
    logic        scan_enable = 1'b0, test_mode = 1'b0;
    logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] SR0 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] SR;
    logic        fmt_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    float_decode dut (
        .clk(clk), .reset(reset),
        .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
        .scan_in3(scan_in3), .scan_in4(scan_in4),
        .scan_enable(scan_enable), .test_mode(test_mode),
        .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
        .scan_out3(scan_out3), .scan_out4(scan_out4),
        .in_valid(in_valid), .in_ready(in_ready), .SR0(SR0),
        .out_valid(out_valid), .out_ready(out_ready),
        .SR(SR), .fmt_err(fmt_err)
    );

    // Value of the float word computed with plain integer arithmetic.
    function automatic logic [15:0] model_sr(input logic [10:0] w);
        int e;
        int m;
        int mag;
        e   = int'(w[9:6]);
        m   = int'(w[5:0]);
        mag = (m * (1 << e)) / 64;
        if (w[10]) return 16'((65536 - mag) % 65536);
        return 16'(mag);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after release.
    task automatic run_word(input logic [10:0] w, input int hold);
        int          lat;
        logic [15:0] exp_sr;
        logic        exp_err;
        logic        busy_ok;
        logic        hold_ok;
        exp_sr  = model_sr(w);
        exp_err = ~w[5];
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        chk("idle_in_ready", in_ready, 1);
        SR0      = w;
        in_valid = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            SR0      = 11'($urandom_range(0, 2047));
            @(negedge clk);
            lat++;
        end
        chk("busy_in_ready_low", busy_ok, 1);
        chk("latency", lat, int'(w[9:6]) + 2);
        chk("SR", SR, exp_sr);
        chk("fmt_err", fmt_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            SR0       = 11'($urandom_range(0, 2047));
            @(negedge clk);
            if (SR !== exp_sr || fmt_err !== exp_err || out_valid !== 1'b1 || in_ready !== 1'b0)
                hold_ok = 1'b0;
        end
        if (hold > 0) chk("hold_stable", hold_ok, 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        SR0       = 11'($urandom_range(0, 2047));
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_out_valid", out_valid, 0);
        chk("release_no_accept", in_ready, 1);
        chk("SR_kept", SR, exp_sr);
    endtask

    initial begin
        int   seen;
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_SR", SR, 16'h0000);
        chk("rst_fmt_err", fmt_err, 0);
        chk("rst_scan_out", {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_word(11'h3FF, 0);
        run_word(11'h568, 1);
        run_word(11'h020, 0);
        run_word(11'h420, 0);
        run_word(11'h0D0, 2);
        run_word(11'h2A5, 5);

        // Abort a long conversion partway through the shift phase.
        SR0      = 11'h3FF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_SR", SR, 16'h0000);
        chk("abort_fmt_err", fmt_err, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_output", seen, 0);
        run_word(11'h040, 0);
        run_word(11'h060, 1);

        for (int i = 0; i < 20; i++)
            run_word(11'($urandom_range(0, 2047)), int'($urandom_range(0, 3)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
